// File: rtl/sr_pq_ctrl.sv
// rtl/sr_pq_ctrl.sv - front-end controller for the shift-register priority queue stage array
//
// Purpose:
//   Turns valid/ready push and pop handshakes into the single-cycle push/pop/kvi
//   broadcast consumed by every stage, tracks occupancy, serves the head item,
//   bypasses a push straight to a same-cycle pop when the pushed key would be the
//   new minimum, and runs a drain-flush sequence.
//
// Optional feature macro: SR_PQ_CTRL_STATS_EN (statistics counters; tied to 0 when undefined).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset (shared with stage array)
//   push_valid/push_ready/push_kv    push handshake and item
//   pop_valid/pop_ready/pop_kv       pop handshake and popped item (valid in the accept cycle)
//   head_kv                          stage 0 kv (current minimum)
//   st_push/st_pop/st_kvi            broadcast to the stage array
//   flush_req                        drain request (level)
//   drain_valid/flush_done           drained item strobe, drain-complete pulse
//   count/full/empty                 occupancy
//   stat_push/stat_pop/stat_byp/stat_hwm  16-bit saturating statistics

module sr_pq_ctrl #(
  parameter int KW    = 4,
  parameter int VW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [KW+VW-1:0]           push_kv,
  input  logic                       pop_valid,
  output logic                       pop_ready,
  output logic [KW+VW-1:0]           pop_kv,
  input  logic [KW+VW-1:0]           head_kv,
  output logic                       st_push,
  output logic                       st_pop,
  output logic [KW+VW-1:0]           st_kvi,
  input  logic                       flush_req,
  output logic                       drain_valid,
  output logic                       flush_done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                stat_push,
  output logic [15:0]                stat_pop,
  output logic [15:0]                stat_byp,
  output logic [15:0]                stat_hwm
);

  localparam int W  = KW + VW;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {S_RUN, S_FLUSH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count_r, count_n;
  logic          flush_pend, flush_pend_n;
  logic          pf, of, byp;

  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      count_r    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      count_r    <= count_n;
      flush_pend <= flush_pend_n;
    end
  end

  always_comb begin
    state_n      = state;
    count_n      = count_r;
    flush_pend_n = flush_pend;
    push_ready   = 1'b0;
    pop_ready    = 1'b0;
    pop_kv       = '0;
    st_push      = 1'b0;
    st_pop       = 1'b0;
    st_kvi       = '0;
    drain_valid  = 1'b0;
    flush_done   = 1'b0;
    pf           = 1'b0;
    of           = 1'b0;
    byp          = 1'b0;
    case (state)
      S_RUN: begin
        // A full queue still accepts a push when a pop retires an item in the same cycle;
        // an empty queue still accepts a pop when a push supplies the item (bypass).
        push_ready = !full || (pop_valid && !empty);
        pop_ready  = !empty || push_valid;
        pf         = push_valid && push_ready;
        of         = pop_valid && pop_ready;
        // Strictly smaller key would become the new head, so hand it straight back.
        // Equal keys go through the array so the older item leaves first.
        byp = pf && of && (empty || (push_kv[W-1:VW] < head_kv[W-1:VW]));
        if (byp) begin
          pop_kv = push_kv;
        end else begin
          st_push = pf;
          st_pop  = of;
          st_kvi  = pf ? push_kv : '0;
          if (of) pop_kv = head_kv;
        end
        if (pf && !of)      count_n = count_r + CW'(1);
        else if (of && !pf) count_n = count_r - CW'(1);
        // A request seen during a busy cycle is remembered and honoured on the next idle cycle.
        if (flush_req || flush_pend) begin
          if (pf || of) begin
            flush_pend_n = 1'b1;
          end else begin
            flush_pend_n = 1'b0;
            state_n      = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (count_r != '0) begin
          st_pop      = 1'b1;
          drain_valid = 1'b1;
          pop_kv      = head_kv;
          count_n     = count_r - CW'(1);
        end else begin
          flush_done = 1'b1;
          state_n    = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

`ifdef SR_PQ_CTRL_STATS_EN
  logic [15:0] stat_push_r, stat_pop_r, stat_byp_r, stat_hwm_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_push_r <= '0;
      stat_pop_r  <= '0;
      stat_byp_r  <= '0;
      stat_hwm_r  <= '0;
    end else begin
      if (pf && stat_push_r != 16'hFFFF) stat_push_r <= stat_push_r + 16'd1;
      if (of && stat_pop_r  != 16'hFFFF) stat_pop_r  <= stat_pop_r  + 16'd1;
      if (byp && stat_byp_r != 16'hFFFF) stat_byp_r  <= stat_byp_r  + 16'd1;
      if (16'(count_n) > stat_hwm_r)     stat_hwm_r  <= 16'(count_n);
    end
  end

  assign stat_push = stat_push_r;
  assign stat_pop  = stat_pop_r;
  assign stat_byp  = stat_byp_r;
  assign stat_hwm  = stat_hwm_r;
`else
  assign stat_push = '0;
  assign stat_pop  = '0;
  assign stat_byp  = '0;
  assign stat_hwm  = '0;
`endif

endmodule
